// File: rtl/collision_sequencer_pkg.sv
// Shared constants for the player collision path: playfield geometry,
// probe side indices, player_state field offsets and the sequencer states.
package slime_pkg;

    localparam int FIELD_X0   = 144;
    localparam int FIELD_Y0   = 35;
    localparam int TILE_SHIFT = 5;
    localparam int SPRITE     = 32;

    localparam logic [1:0] LEFT  = 2'd0;
    localparam logic [1:0] BOT   = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] TOP   = 2'd3;

    // player_state = {xPos, yPos, xSpeed, ySpeed, xDir, yDir}
    localparam int XPOS_LSB = 22;
    localparam int YPOS_LSB = 12;
    localparam int XSPD_LSB = 7;
    localparam int YSPD_LSB = 2;
    localparam int XDIR_BIT = 1;
    localparam int YDIR_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        DRAIN,
        DONE
    } seq_state_e;

    // Probe point on one side of the sprite at predicted corner (nx, ny).
    function automatic logic [21:0] probe_pt(
        input logic [1:0]  side,
        input logic [10:0] nx,
        input logic [10:0] ny
    );
        logic [10:0] px;
        logic [10:0] py;
        px = nx;
        py = ny;
        unique case (side)
            LEFT: begin
                py = ny + 11'(SPRITE / 2);
            end
            BOT: begin
                px = nx + 11'(SPRITE / 2);
                py = ny + 11'(SPRITE - 1);
            end
            RIGHT: begin
                px = nx + 11'(SPRITE - 1);
                py = ny + 11'(SPRITE / 2);
            end
            TOP: begin
                px = nx + 11'(SPRITE / 2);
            end
        endcase
        return {px, py};
    endfunction

endpackage

// File: rtl/collision_sequencer_if.sv
// Tile-map read port shared between the renderer and the sequencer.
// master: arbiter side (drives map_addr, rdr_gnt); slave: map + renderer.
interface collision_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int TILE_W = 4
);
    logic              rdr_req;
    logic [ADDR_W-1:0] rdr_addr;
    logic              rdr_gnt;
    logic [ADDR_W-1:0] map_addr;
    logic [TILE_W-1:0] map_data;

    modport master (
        input  rdr_req, rdr_addr, map_data,
        output rdr_gnt, map_addr
    );

    modport slave (
        output rdr_req, rdr_addr, map_data,
        input  rdr_gnt, map_addr
    );
endinterface

// File: rtl/collision_sequencer_tile_probe_addr.sv
// Maps a pixel point to its tile-map address and flags points off the field.
// Ports: px, py (11-bit pixel) -> addr (tile index), out_of_field.
module tile_probe_addr
    import slime_pkg::*;
#(
    parameter int MAP_COLS = 20,
    parameter int MAP_ROWS = 15,
    parameter int ADDR_W   = 9
) (
    input  logic [10:0]       px,
    input  logic [10:0]       py,
    output logic [ADDR_W-1:0] addr,
    output logic              out_of_field
);
    localparam int X_MAX = FIELD_X0 + MAP_COLS * SPRITE - 1;
    localparam int Y_MAX = FIELD_Y0 + MAP_ROWS * SPRITE - 1;

    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;

    assign dx   = px - 11'(FIELD_X0);
    assign dy   = py - 11'(FIELD_Y0);
    assign col  = ADDR_W'(dx >> TILE_SHIFT);
    assign row  = ADDR_W'(dy >> TILE_SHIFT);
    assign addr = row * ADDR_W'(MAP_COLS) + col;

    assign out_of_field = px[10] | py[10]
                        | (px < 11'(FIELD_X0)) | (px > 11'(X_MAX))
                        | (py < 11'(FIELD_Y0)) | (py > 11'(Y_MAX));
endmodule

// File: rtl/collision_sequencer.sv
// Per-tick collision scheduler: predicts the next sprite position, probes four
// sides through the shared map port (renderer has priority) and reports
// player_col with a col_valid pulse. Ports: sim_clk, reset, tick,
// player_state, map (port interface), player_col, col_valid, busy, tick_overrun.
module collision_sequencer
    import slime_pkg::*;
#(
    parameter int MAP_COLS = 20,
    parameter int MAP_ROWS = 15,
    parameter int ADDR_W   = 9,
    parameter int TILE_W   = 4
) (
    input  logic                         sim_clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [31:0]                  player_state,
    collision_sequencer_if.master        map,
    output logic [3:0]                   player_col,
    output logic                         col_valid,
    output logic                         busy,
    output logic                         tick_overrun
);
    seq_state_e  state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] ps_q, ps_d;
    logic [3:0]  res_q, res_d;
    logic        iss_q, iss_d;
    logic [1:0]  iss_side_q, iss_side_d;
    logic [3:0]  col_q, col_d;
    logic        ovr_q, ovr_d;

    logic [9:0]        x, y;
    logic [4:0]        xs, ys;
    logic [10:0]       nx, ny, px, py;
    logic [ADDR_W-1:0] probe_addr;
    logic              probe_oof;
    logic [ADDR_W-1:0] map_addr_c;

    assign x  = ps_q[XPOS_LSB +: 10];
    assign y  = ps_q[YPOS_LSB +: 10];
    assign xs = ps_q[XSPD_LSB +: 5];
    assign ys = ps_q[YSPD_LSB +: 5];

    // 11-bit wrap on underflow sets bit 10, which reads as off-field.
    assign nx = ps_q[XDIR_BIT] ? {1'b0, x} + {6'd0, xs}
                               : {1'b0, x} - {6'd0, xs};
    assign ny = ps_q[YDIR_BIT] ? {1'b0, y} - {6'd0, ys}
                               : {1'b0, y} + {6'd0, ys};

    assign {px, py} = probe_pt(k_q, nx, ny);

    tile_probe_addr #(
        .MAP_COLS(MAP_COLS),
        .MAP_ROWS(MAP_ROWS),
        .ADDR_W  (ADDR_W)
    ) u_addr (
        .px          (px),
        .py          (py),
        .addr        (probe_addr),
        .out_of_field(probe_oof)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ps_d       = ps_q;
        res_d      = res_q;
        iss_d      = 1'b0;
        iss_side_d = iss_side_q;
        col_d      = col_q;
        ovr_d      = ovr_q;
        map_addr_c = map.rdr_addr;

        // Only slots the sequencer itself issued return data to it.
        if (iss_q && (map.map_data != TILE_W'(0))) begin
            res_d[iss_side_q] = 1'b1;
        end

        if (tick && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    ps_d    = player_state;
                    k_d     = LEFT;
                    res_d   = 4'd0;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (!map.rdr_req) begin
                    if (probe_oof) begin
                        res_d[k_q] = 1'b1;
                    end else begin
                        map_addr_c = probe_addr;
                        iss_d      = 1'b1;
                        iss_side_d = k_q;
                    end
                    k_d = k_q + 2'd1;
                    if (k_q == TOP) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                col_d   = res_d;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= LEFT;
            ps_q       <= 32'd0;
            res_q      <= 4'd0;
            iss_q      <= 1'b0;
            iss_side_q <= LEFT;
            col_q      <= 4'd0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ps_q       <= ps_d;
            res_q      <= res_d;
            iss_q      <= iss_d;
            iss_side_q <= iss_side_d;
            col_q      <= col_d;
            ovr_q      <= ovr_d;
        end
    end

    assign map.map_addr = map_addr_c;
    assign map.rdr_gnt  = map.rdr_req;
    assign player_col   = col_q;
    assign col_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign tick_overrun = ovr_q;
endmodule

// File: tb/tb_collision_sequencer.sv
// Randomised and directed bench for collision_sequencer with a
// behavioural tile-map model and pixel-geometry reference.
module tb_collision_sequencer;
    localparam int NW = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [31:0] player_state;
    logic [3:0]  player_col;
    logic        col_valid;
    logic        busy;
    logic        tick_overrun;

    collision_sequencer_if #(.ADDR_W(9), .TILE_W(4)) mif ();

    collision_sequencer dut (
        .sim_clk     (clk),
        .reset       (reset),
        .tick        (tick),
        .player_state(player_state),
        .map         (mif.master),
        .player_col  (player_col),
        .col_valid   (col_valid),
        .busy        (busy),
        .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    logic [3:0] map_mem [0:511];

    always @(posedge clk) mif.map_data <= map_mem[mif.map_addr];

    int n_cmp = 0;
    int n_err = 0;

    logic       busy_tr [NW];
    logic       cv_tr   [NW];
    logic       gnt_tr  [NW];
    logic [8:0] addr_tr [NW];
    logic [3:0] col_tr  [NW];

    int         exp_addr [4];
    bit         exp_oof  [4];
    logic [3:0] exp_col;

    function automatic logic [31:0] pack(int x, int y, int xs, int ys,
                                         bit xd, bit yd);
        return {10'(x), 10'(y), 5'(xs), 5'(ys), xd, yd};
    endfunction

    task automatic clear_map();
        for (int i = 0; i < 512; i++) map_mem[i] = 4'd0;
    endtask

    // Pixel-level prediction of the four probes and the collision vector.
    task automatic predict(input logic [31:0] ps);
        int x, y, xs, ys, nx, ny;
        int px [4];
        int py [4];
        x  = int'(ps[31:22]);
        y  = int'(ps[21:12]);
        xs = int'(ps[11:7]);
        ys = int'(ps[6:2]);
        nx = ps[1] ? x + xs : x - xs;
        ny = ps[0] ? y - ys : y + ys;
        px = '{nx, nx + 16, nx + 31, nx + 16};
        py = '{ny + 16, ny + 31, ny + 16, ny};
        exp_col = 4'd0;
        for (int i = 0; i < 4; i++) begin
            exp_oof[i] = px[i] < 144 || px[i] > 783
                      || py[i] < 35  || py[i] > 514;
            exp_addr[i] = exp_oof[i] ? 0
                        : ((py[i] - 35) / 32) * 20 + (px[i] - 144) / 32;
            exp_col[i] = exp_oof[i] ? 1'b1 : (map_mem[exp_addr[i]] != 4'd0);
        end
    endtask

    // Offset of the i-th cycle (from T+1) in which the renderer is quiet.
    function automatic int slot_of(logic [15:0] stall, int i);
        int n = 0;
        for (int off = 1; off < 16; off++) begin
            if (!stall[off]) begin
                if (n == i) return off;
                n++;
            end
        end
        return NW - 1;
    endfunction

    // Tick at offset 0, then record outputs for NW cycles.
    task automatic run_tick(input logic [31:0] ps, input logic [15:0] stall,
                            input int t2, input int rst_at,
                            input logic [8:0] raddr);
        for (int off = 0; off < NW; off++) begin
            tick         = (off == 0) || (off == t2);
            player_state = ps;
            mif.rdr_req  = stall[off];
            mif.rdr_addr = raddr;
            reset        = (off == rst_at);
            #1;
            busy_tr[off] = busy;
            cv_tr[off]   = col_valid;
            gnt_tr[off]  = mif.rdr_gnt;
            addr_tr[off] = mif.map_addr;
            col_tr[off]  = player_col;
            @(posedge clk);
            #1;
        end
        tick        = 1'b0;
        mif.rdr_req = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        tick         = 1'b0;
        player_state = 32'd0;
        mif.rdr_req  = 1'b1;
        mif.rdr_addr = 9'd123;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (player_col !== 4'd0) begin
            n_err++; $display("FAIL rst_col: got %0h want 0", player_col);
        end
        n_cmp++;
        if (col_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_cv: got %0b want 0", col_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL rst_busy: got %0b want 0", busy);
        end
        n_cmp++;
        if (tick_overrun !== 1'b0) begin
            n_err++; $display("FAIL rst_ovr: got %0b want 0", tick_overrun);
        end
        n_cmp++;
        if (mif.rdr_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_gnt1: got %0b want 1", mif.rdr_gnt);
        end
        n_cmp++;
        if (mif.map_addr !== 9'd123) begin
            n_err++; $display("FAIL rst_addr: got %0d want 123", mif.map_addr);
        end
        mif.rdr_req = 1'b0;
        #1;
        n_cmp++;
        if (mif.rdr_gnt !== 1'b0) begin
            n_err++; $display("FAIL rst_gnt0: got %0b want 0", mif.rdr_gnt);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_map();
        logic [31:0] ps;
        clear_map();
        ps = pack(176, 99, 2, 0, 1'b1, 1'b0);
        predict(ps);
        run_tick(ps, 16'd0, -1, -1, 9'd7);
        for (int off = 0; off < NW; off++) begin
            n_cmp++;
            if (cv_tr[off] !== (off == 6)) begin
                n_err++;
                $display("FAIL empty_cv@%0d: got %0b want %0b",
                         off, cv_tr[off], off == 6);
            end
            n_cmp++;
            if (busy_tr[off] !== (off >= 1 && off <= 6)) begin
                n_err++;
                $display("FAIL empty_busy@%0d: got %0b want %0b",
                         off, busy_tr[off], off >= 1 && off <= 6);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_tr[i + 1] !== 9'(exp_addr[i])) begin
                n_err++;
                $display("FAIL empty_addr%0d: got %0d want %0d",
                         i, addr_tr[i + 1], exp_addr[i]);
            end
        end
        n_cmp++;
        if (col_tr[6] !== 4'b0000) begin
            n_err++; $display("FAIL empty_col: got %b want 0000", col_tr[6]);
        end
    endtask

    task automatic test_solid_tile();
        logic [31:0] ps;
        clear_map();
        map_mem[42] = 4'd5;
        ps = pack(176, 99, 2, 0, 1'b1, 1'b0);
        predict(ps);
        run_tick(ps, 16'd0, -1, -1, 9'd0);
        n_cmp++;
        if (col_tr[5] !== 4'b0000) begin
            n_err++; $display("FAIL solid_pre: got %b want 0000", col_tr[5]);
        end
        n_cmp++;
        if (col_tr[6] !== exp_col || exp_col !== 4'b0100) begin
            n_err++;
            $display("FAIL solid_col: got %b want %b", col_tr[6], exp_col);
        end
        n_cmp++;
        if (col_tr[NW - 1] !== exp_col) begin
            n_err++;
            $display("FAIL solid_hold: got %b want %b", col_tr[NW - 1], exp_col);
        end
    endtask

    task automatic test_out_of_field();
        logic [31:0] ps;
        clear_map();
        ps = pack(144, 99, 2, 0, 1'b0, 1'b0);
        predict(ps);
        run_tick(ps, 16'd0, -1, -1, 9'd0);
        n_cmp++;
        if (col_tr[6] !== exp_col || exp_col !== 4'b0001) begin
            n_err++;
            $display("FAIL oof_col: got %b want %b", col_tr[6], exp_col);
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (addr_tr[i + 1] !== 9'(exp_addr[i])) begin
                n_err++;
                $display("FAIL oof_addr%0d: got %0d want %0d",
                         i, addr_tr[i + 1], exp_addr[i]);
            end
        end
        n_cmp++;
        if (cv_tr[6] !== 1'b1) begin
            n_err++; $display("FAIL oof_cv: got %0b want 1", cv_tr[6]);
        end
    endtask

    task automatic test_renderer_stall();
        logic [31:0] ps;
        logic [15:0] stall;
        int          s;
        clear_map();
        map_mem[42]  = 4'd1;
        map_mem[250] = 4'd9;
        stall = 16'b0000_0000_0001_1100;
        ps = pack(176, 99, 2, 0, 1'b1, 1'b0);
        predict(ps);
        run_tick(ps, stall, -1, -1, 9'd250);
        for (int off = 0; off < NW; off++) begin
            n_cmp++;
            if (gnt_tr[off] !== stall[off]) begin
                n_err++;
                $display("FAIL stall_gnt@%0d: got %0b want %0b",
                         off, gnt_tr[off], stall[off]);
            end
            if (stall[off]) begin
                n_cmp++;
                if (addr_tr[off] !== 9'd250) begin
                    n_err++;
                    $display("FAIL stall_raddr@%0d: got %0d want 250",
                             off, addr_tr[off]);
                end
            end
            n_cmp++;
            if (cv_tr[off] !== (off == 9)) begin
                n_err++;
                $display("FAIL stall_cv@%0d: got %0b want %0b",
                         off, cv_tr[off], off == 9);
            end
        end
        for (int i = 0; i < 4; i++) begin
            s = slot_of(stall, i);
            n_cmp++;
            if (addr_tr[s] !== 9'(exp_addr[i])) begin
                n_err++;
                $display("FAIL stall_addr%0d: got %0d want %0d",
                         i, addr_tr[s], exp_addr[i]);
            end
        end
        n_cmp++;
        if (col_tr[9] !== 4'b0100) begin
            n_err++; $display("FAIL stall_col: got %b want 0100", col_tr[9]);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] ps;
        int          ncv;
        clear_map();
        map_mem[42] = 4'd3;
        ps = pack(176, 99, 2, 0, 1'b1, 1'b0);
        n_cmp++;
        if (tick_overrun !== 1'b0) begin
            n_err++; $display("FAIL ovr_pre: got %0b want 0", tick_overrun);
        end
        run_tick(ps, 16'd0, 3, -1, 9'd0);
        ncv = 0;
        for (int off = 0; off < NW; off++) ncv += int'(cv_tr[off]);
        n_cmp++;
        if (ncv != 1 || cv_tr[6] !== 1'b1) begin
            n_err++; $display("FAIL ovr_cv: got %0d pulses want 1 at 6", ncv);
        end
        n_cmp++;
        if (col_tr[6] !== 4'b0100) begin
            n_err++; $display("FAIL ovr_col: got %b want 0100", col_tr[6]);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (tick_overrun !== 1'b1) begin
            n_err++; $display("FAIL ovr_sticky: got %0b want 1", tick_overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ps;
        int          ncv;
        clear_map();
        map_mem[42] = 4'd2;
        ps = pack(176, 99, 2, 0, 1'b1, 1'b0);
        run_tick(ps, 16'd0, -1, -1, 9'd0);
        n_cmp++;
        if (col_tr[6] !== 4'b0100) begin
            n_err++; $display("FAIL rmid_pre: got %b want 0100", col_tr[6]);
        end
        run_tick(ps, 16'd0, -1, 3, 9'd0);
        ncv = 0;
        for (int off = 0; off < NW; off++) ncv += int'(cv_tr[off]);
        n_cmp++;
        if (ncv != 0) begin
            n_err++; $display("FAIL rmid_cv: got %0d pulses want 0", ncv);
        end
        n_cmp++;
        if (busy_tr[4] !== 1'b0) begin
            n_err++; $display("FAIL rmid_busy: got %0b want 0", busy_tr[4]);
        end
        n_cmp++;
        if (col_tr[4] !== 4'b0000 || col_tr[NW - 1] !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_col: got %b/%b want 0000",
                     col_tr[4], col_tr[NW - 1]);
        end
        n_cmp++;
        if (tick_overrun !== 1'b0) begin
            n_err++; $display("FAIL rmid_ovr: got %0b want 0", tick_overrun);
        end
        run_tick(ps, 16'd0, -1, -1, 9'd0);
        n_cmp++;
        if (cv_tr[6] !== 1'b1 || col_tr[6] !== 4'b0100) begin
            n_err++;
            $display("FAIL rmid_fresh: got cv=%0b col=%b want 1/0100",
                     cv_tr[6], col_tr[6]);
        end
    endtask

    task automatic test_random();
        logic [31:0] ps;
        logic [15:0] stall;
        int          s, s3, ncv;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 512; i++) begin
                map_mem[i] = ($urandom_range(0, 3) == 0)
                           ? 4'($urandom_range(1, 15)) : 4'd0;
            end
            ps = pack($urandom_range(100, 850), $urandom_range(0, 560),
                      $urandom_range(0, 31), $urandom_range(0, 31),
                      1'($urandom), 1'($urandom));
            stall = 16'($urandom_range(0, 7)) << 1;
            predict(ps);
            run_tick(ps, stall, -1, -1, 9'($urandom_range(0, 299)));
            s3  = slot_of(stall, 3);
            ncv = 0;
            for (int off = 0; off < NW; off++) ncv += int'(cv_tr[off]);
            n_cmp++;
            if (ncv != 1 || cv_tr[s3 + 2] !== 1'b1) begin
                n_err++;
                $display("FAIL rnd%0d_cv: got %0d pulses want 1 at %0d",
                         it, ncv, s3 + 2);
            end
            n_cmp++;
            if (col_tr[s3 + 2] !== exp_col) begin
                n_err++;
                $display("FAIL rnd%0d_col: got %b want %b ps=%h",
                         it, col_tr[s3 + 2], exp_col, ps);
            end
            for (int i = 0; i < 4; i++) begin
                if (!exp_oof[i]) begin
                    s = slot_of(stall, i);
                    n_cmp++;
                    if (addr_tr[s] !== 9'(exp_addr[i])) begin
                        n_err++;
                        $display("FAIL rnd%0d_addr%0d: got %0d want %0d",
                                 it, i, addr_tr[s], exp_addr[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        clear_map();
        test_reset();
        test_empty_map();
        test_solid_tile();
        test_out_of_field();
        test_renderer_stall();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/collision_sequencer.md
# collision_sequencer

Per-frame collision scheduler for the player physics datapath. On each simulation tick it takes the player's state vector and predicts the next position. It then probes the tile map at four sides of the 32x32 sprite through the single tile-map read port, which it shares with the renderer. It delivers the 4-bit collision vector the player module consumes.

## Interface
- MAP_COLS, 20: tiles per row (640 px / 32)
- MAP_ROWS, 15: tile rows (480 px / 32)
- ADDR_W, 9: tile-map address width
- TILE_W, 4: tile code width; nonzero = solid
- sim_clk  in  1  clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle strobe, start of a physics step
- player_state  in  32  {xPos[9:0], yPos[9:0], xSpeed[4:0], ySpeed[4:0], xDir, yDir}; xDir 1=right, yDir 0=down
- rdr_req  in  1  renderer wants the map port this cycle
- rdr_addr  in  ADDR_W  renderer address
- rdr_gnt  out  1  renderer owns the port this cycle
- map_addr  out  ADDR_W  tile-map read address (combinational)
- map_data  in  TILE_W  read data, valid one cycle after address
- player_col  out  4  [0]=left, [1]=bottom, [2]=right, [3]=top; held between updates
- col_valid  out  1  one-cycle pulse when player_col updates
- busy  out  1  sequence in progress
- tick_overrun  out  1  sticky: tick arrived while busy

## Operation
- States: IDLE, PROBE, DRAIN, DONE.
- IDLE:
  - When tick is high, latch player_state and enter PROBE with side index k=0.
- Predicted position, in 11-bit unsigned arithmetic:
  - nx = xDir ? x+xSpeed : x-xSpeed
  - ny = yDir ? y-ySpeed : y+ySpeed
- Probe points:
  - left (nx, ny+16)
  - bottom (nx+16, ny+31)
  - right (nx+31, ny+16)
  - top (nx+16, ny)
- Tile address = ((py-35)>>5)*MAP_COLS + ((px-144)>>5).
- Out-of-field point: bit 10 set, or px<144, px>783, py<35, or py>514.
  - Treated as solid with no read.
  - Still consumes its slot.
- PROBE:
  - Each un-stalled cycle issues side k and increments k.
  - After k=3 is issued, go to DRAIN.
  - Data for side k is captured the cycle after it was issued: solid = (map_data != 0).
- DRAIN: capture the last result, then go to DONE.
- DONE: load player_col, pulse col_valid, return to IDLE.
- Arbitration: the renderer has absolute priority.
  - While rdr_req=1: rdr_gnt=1, map_addr=rdr_addr, the sequencer holds k and issues nothing.
  - A per-slot "issued" flag routes returning data. Data read for the renderer is never captured.
- When the sequencer is idle, map_addr = rdr_addr.
- tick while busy: ignored, and tick_overrun is set.
- Reset values: player_col=0, col_valid=0, busy=0, tick_overrun=0, rdr_gnt=rdr_req, state IDLE.
- Reset mid-sequence: abort, discard partial results, hold player_col at 0.

## Timing
- tick sampled at cycle T.
- No contention:
  - Sides 0..3 are issued at T+1..T+4 and captured at T+2..T+5.
  - player_col is valid from T+6, with col_valid high during T+6.
- Each stalled cycle while busy adds exactly one cycle.
- busy is high T+1 through T+6 inclusive. A tick at T+7 is accepted.
- Back-to-back: the earliest accepted next tick is the cycle after col_valid.

## Structure
- Package slime_pkg holds:
  - FIELD_X0=144, FIELD_Y0=35, TILE_SHIFT=5, SPRITE=32
  - side indices LEFT/BOT/RIGHT/TOP = 0..3
  - the player_state field offsets, shared with the player module
- Sub-module tile_probe_addr: combinational; (px, py) -> {addr, out_of_field}. It is instanced once and muxed by k.

## Test plan
- Empty map; x=176, y=99, xSpeed=2, ySpeed=0, right/down; tick at T -> player_col=0000, col_valid only at T+6, map_addr sequence is the four computed addresses.
- Tile 42 (row 2, col 2) solid; same state -> right probe (209,115) -> player_col=0100.
- x=144, left, xSpeed=2 -> nx=142 out-of-field -> player_col[0]=1 with no read issued in that slot; other sides read normally.
- rdr_req high T+2..T+4 -> rdr_gnt mirrors it, map_addr=rdr_addr in those cycles, col_valid at T+9, results identical to the uncontended run.
- Second tick at T+3 -> ignored, tick_overrun=1 until reset, single col_valid.
- reset at T+3 -> busy=0, player_col=0000, no col_valid; a fresh tick then completes in 6 cycles.
